// File: rtl/decode_pkg.sv
// ---------------------------------------------------------------------------
// decode_pkg
// Shared definitions for the decode stage:
//   - register file geometry
//   - supported opcodes
//   - field positions inside the 150-bit ID_EX latch
//   - decode state encodings
//   - a sign-extension helper
// No ports; imported by decode_stage and decode_stage_regfile.
// ---------------------------------------------------------------------------
package decode_pkg;

    // Register file geometry
    localparam int RF_DEPTH = 32;
    localparam int RF_IDX_W = 5;

    // Supported opcodes (instr[31:26])
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_J     = 6'h02;

    // ID_EX latch layout
    localparam int IDEX_W         = 150;
    localparam int IDEX_VALID     = 149;
    localparam int IDEX_REG_WRITE = 148;
    localparam int IDEX_MEM_READ  = 147;
    localparam int IDEX_MEM_WRITE = 146;
    localparam int IDEX_ALU_SRC   = 145;
    localparam int IDEX_OP_HI     = 144;
    localparam int IDEX_OP_LO     = 139;
    localparam int IDEX_FUNCT_HI  = 138;
    localparam int IDEX_FUNCT_LO  = 133;
    localparam int IDEX_DEST_HI   = 132;
    localparam int IDEX_DEST_LO   = 128;
    localparam int IDEX_PC_HI     = 127;
    localparam int IDEX_PC_LO     = 96;
    localparam int IDEX_RS_HI     = 95;
    localparam int IDEX_RS_LO     = 64;
    localparam int IDEX_RT_HI     = 63;
    localparam int IDEX_RT_LO     = 32;
    localparam int IDEX_IMM_HI    = 31;
    localparam int IDEX_IMM_LO    = 0;

    // Decode state encodings
    typedef enum logic [1:0] {
        ST_RESET_IDLE = 2'b00,
        ST_RUN        = 2'b01,
        ST_FLUSH      = 2'b10
    } dec_state_t;

    // Sign-extend a 16-bit immediate to 32 bits
    function automatic logic [31:0] sext16(input logic [15:0] imm);
        return {{16{imm[15]}}, imm};
    endfunction

endpackage

// File: rtl/decode_stage_regfile.sv
// ---------------------------------------------------------------------------
// decode_stage_regfile
// 32x32 register file owned by the decode stage.
//   - one write port, used by writeback
//   - two combinational read ports with write-through bypass
//   - register 0 always reads as zero
//   - asynchronous active-low clear of all entries
// Ports:
//   clock, reset          : rising-edge clock, async active-low reset
//   we, waddr, wdata      : write port (ignored for address 0)
//   ra_addr -> ra_data    : read port A
//   rb_addr -> rb_data    : read port B
// ---------------------------------------------------------------------------
module decode_stage_regfile
    import decode_pkg::*;
#(
    parameter int NREGS = RF_DEPTH,
    parameter int IDX_W = RF_IDX_W
)
(
    input  logic             clock,
    input  logic             reset,
    input  logic             we,
    input  logic [IDX_W-1:0] waddr,
    input  logic [31:0]      wdata,
    input  logic [IDX_W-1:0] ra_addr,
    output logic [31:0]      ra_data,
    input  logic [IDX_W-1:0] rb_addr,
    output logic [31:0]      rb_data
);

    logic [31:0] mem_r [NREGS];

    // Storage array: async clear on reset, write on the rising edge
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREGS; i++) begin
                mem_r[i] <= 32'd0;
            end
        end else if (we && (waddr != {IDX_W{1'b0}})) begin
            mem_r[waddr] <= wdata;
        end
    end

    // Read port A: zero register, then same-cycle writeback bypass, then array
    always_comb begin
        ra_data = 32'd0;
        if (ra_addr == {IDX_W{1'b0}}) begin
            ra_data = 32'd0;
        end else if (we && (ra_addr == waddr)) begin
            ra_data = wdata;
        end else begin
            ra_data = mem_r[ra_addr];
        end
    end

    // Read port B: same priority as port A
    always_comb begin
        rb_data = 32'd0;
        if (rb_addr == {IDX_W{1'b0}}) begin
            rb_data = 32'd0;
        end else if (we && (rb_addr == waddr)) begin
            rb_data = wdata;
        end else begin
            rb_data = mem_r[rb_addr];
        end
    end

endmodule

// File: rtl/decode_stage.sv
// ---------------------------------------------------------------------------
// decode_stage
// Consumer of the IF_ID latch and producer of the ID_EX latch.
//   - decodes the fetched word and reads the owned register file
//   - resolves BEQ / J inside the stage
//   - detects load-use and branch-operand hazards
// Ports:
//   clock, reset        : rising-edge clock, async active-low reset
//   IF_ID, if_valid     : {pc, instruction} from fetch, and its valid bit
//   ex_dest/ex_regwrite : destination held in the EX/MEM latch
//   wb_we/addr/data     : writeback port into the register file
//   stall               : combinational; fetch holds pc and IF_ID
//   branchFlag/Target   : combinational redirect request to fetch
//   ID_EX               : registered 150-bit latch toward execute
// ---------------------------------------------------------------------------
module decode_stage
    import decode_pkg::*;
#(
    parameter int NREGS = RF_DEPTH,
    parameter int IDX_W = RF_IDX_W
)
(
    input  logic              clock,
    input  logic              reset,
    input  logic [63:0]       IF_ID,
    input  logic              if_valid,
    input  logic [IDX_W-1:0]  ex_dest,
    input  logic              ex_regwrite,
    input  logic              wb_we,
    input  logic [IDX_W-1:0]  wb_addr,
    input  logic [31:0]       wb_data,
    output logic              stall,
    output logic              branchFlag,
    output logic [31:0]       branchTarget,
    output logic [IDEX_W-1:0] ID_EX
);

    dec_state_t       state_r;
    dec_state_t       state_nxt_s;

    logic [31:0]      pc_s;
    logic [31:0]      instr_s;
    logic [5:0]       op_s;
    logic [IDX_W-1:0] rs_s;
    logic [IDX_W-1:0] rt_s;
    logic [IDX_W-1:0] rd_s;
    logic [31:0]      imm_s;
    logic [31:0]      rs_val_s;
    logic [31:0]      rt_val_s;

    logic             ctl_reg_write_s;
    logic             ctl_mem_read_s;
    logic             ctl_mem_write_s;
    logic             ctl_alu_src_s;
    logic [IDX_W-1:0] dest_s;
    logic             uses_rs_s;
    logic             uses_rt_s;

    logic             idex_valid_s;
    logic             idex_reg_write_s;
    logic             idex_mem_read_s;
    logic [IDX_W-1:0] idex_dest_s;

    logic             active_s;
    logic             load_use_s;
    logic             br_hazard_s;
    logic             hazard_s;
    logic             issue_s;
    logic             taken_s;
    logic [31:0]      target_s;
    logic [IDEX_W-1:0] id_ex_nxt_s;

    assign pc_s    = IF_ID[63:32];
    assign instr_s = IF_ID[31:0];
    assign op_s    = instr_s[31:26];
    assign rs_s    = instr_s[25:21];
    assign rt_s    = instr_s[20:16];
    assign rd_s    = instr_s[15:11];
    assign imm_s   = sext16(instr_s[15:0]);

    // Fields of the instruction currently sitting in ID_EX
    assign idex_valid_s     = ID_EX[IDEX_VALID];
    assign idex_reg_write_s = ID_EX[IDEX_REG_WRITE];
    assign idex_mem_read_s  = ID_EX[IDEX_MEM_READ];
    assign idex_dest_s      = ID_EX[IDEX_DEST_HI:IDEX_DEST_LO];

    decode_stage_regfile #(
        .NREGS (NREGS),
        .IDX_W (IDX_W)
    ) u_regfile (
        .clock   (clock),
        .reset   (reset),
        .we      (wb_we),
        .waddr   (wb_addr),
        .wdata   (wb_data),
        .ra_addr (rs_s),
        .ra_data (rs_val_s),
        .rb_addr (rt_s),
        .rb_data (rt_val_s)
    );

    // Control decode: control bits, destination and operand usage per opcode
    always_comb begin
        ctl_reg_write_s = 1'b0;
        ctl_mem_read_s  = 1'b0;
        ctl_mem_write_s = 1'b0;
        ctl_alu_src_s   = 1'b0;
        dest_s          = {IDX_W{1'b0}};
        uses_rs_s       = 1'b0;
        uses_rt_s       = 1'b0;
        case (op_s)
            OP_RTYPE: begin
                ctl_reg_write_s = 1'b1;
                dest_s          = rd_s;
                uses_rs_s       = 1'b1;
                uses_rt_s       = 1'b1;
            end
            OP_ADDI: begin
                ctl_reg_write_s = 1'b1;
                ctl_alu_src_s   = 1'b1;
                dest_s          = rt_s;
                uses_rs_s       = 1'b1;
            end
            OP_LW: begin
                ctl_reg_write_s = 1'b1;
                ctl_mem_read_s  = 1'b1;
                ctl_alu_src_s   = 1'b1;
                dest_s          = rt_s;
                uses_rs_s       = 1'b1;
            end
            OP_SW: begin
                ctl_mem_write_s = 1'b1;
                ctl_alu_src_s   = 1'b1;
                uses_rs_s       = 1'b1;
                uses_rt_s       = 1'b1;
            end
            OP_BEQ: begin
                uses_rs_s       = 1'b1;
                uses_rt_s       = 1'b1;
            end
            default: begin
                // J and unknown opcodes carry no control and read no operands
                ctl_reg_write_s = 1'b0;
            end
        endcase
    end

    // Hazard detection; only meaningful for a real instruction in RUN.
    // Writeback in the same cycle does not clear a hazard.
    always_comb begin
        active_s    = reset && if_valid && (state_r == ST_RUN);
        load_use_s  = 1'b0;
        br_hazard_s = 1'b0;
        if (idex_valid_s && idex_mem_read_s && (idex_dest_s != {IDX_W{1'b0}})) begin
            load_use_s = (uses_rs_s && (rs_s == idex_dest_s)) ||
                         (uses_rt_s && (rt_s == idex_dest_s));
        end else begin
            load_use_s = 1'b0;
        end
        if (op_s == OP_BEQ) begin
            br_hazard_s =
                ((rs_s != {IDX_W{1'b0}}) &&
                 ((idex_reg_write_s && (rs_s == idex_dest_s)) ||
                  (ex_regwrite      && (rs_s == ex_dest)))) ||
                ((rt_s != {IDX_W{1'b0}}) &&
                 ((idex_reg_write_s && (rt_s == idex_dest_s)) ||
                  (ex_regwrite      && (rt_s == ex_dest))));
        end else begin
            br_hazard_s = 1'b0;
        end
        hazard_s = active_s && (load_use_s || br_hazard_s);
        issue_s  = active_s && !hazard_s;
    end

    // Branch resolution and redirect target
    always_comb begin
        taken_s  = 1'b0;
        target_s = 32'd0;
        if (issue_s && (op_s == OP_BEQ) && (rs_val_s == rt_val_s)) begin
            taken_s  = 1'b1;
            target_s = pc_s + 32'd1 + imm_s;
        end else if (issue_s && (op_s == OP_J)) begin
            taken_s  = 1'b1;
            target_s = {6'd0, instr_s[25:0]};
        end else begin
            taken_s  = 1'b0;
            target_s = 32'd0;
        end
    end

    assign stall        = hazard_s;
    assign branchFlag   = taken_s;
    assign branchTarget = target_s;

    // Next ID_EX word: decoded instruction when issuing, otherwise a bubble
    always_comb begin
        id_ex_nxt_s = {IDEX_W{1'b0}};
        if (issue_s) begin
            id_ex_nxt_s[IDEX_VALID]                    = 1'b1;
            id_ex_nxt_s[IDEX_REG_WRITE]                = ctl_reg_write_s;
            id_ex_nxt_s[IDEX_MEM_READ]                 = ctl_mem_read_s;
            id_ex_nxt_s[IDEX_MEM_WRITE]                = ctl_mem_write_s;
            id_ex_nxt_s[IDEX_ALU_SRC]                  = ctl_alu_src_s;
            id_ex_nxt_s[IDEX_OP_HI:IDEX_OP_LO]         = op_s;
            id_ex_nxt_s[IDEX_FUNCT_HI:IDEX_FUNCT_LO]   = instr_s[5:0];
            id_ex_nxt_s[IDEX_DEST_HI:IDEX_DEST_LO]     = dest_s;
            id_ex_nxt_s[IDEX_PC_HI:IDEX_PC_LO]         = pc_s;
            id_ex_nxt_s[IDEX_RS_HI:IDEX_RS_LO]         = rs_val_s;
            id_ex_nxt_s[IDEX_RT_HI:IDEX_RT_LO]         = rt_val_s;
            id_ex_nxt_s[IDEX_IMM_HI:IDEX_IMM_LO]       = imm_s;
        end else begin
            id_ex_nxt_s = {IDEX_W{1'b0}};
        end
    end

    // Next-state logic: a stale post-reset word and a wrong-path word are
    // each squashed for one cycle; a taken branch arms the squash
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_RESET_IDLE: state_nxt_s = ST_RUN;
            ST_RUN: begin
                if (taken_s) begin
                    state_nxt_s = ST_FLUSH;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_FLUSH:      state_nxt_s = ST_RUN;
            default:       state_nxt_s = ST_RESET_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r <= ST_RESET_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // ID_EX pipeline latch
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ID_EX <= {IDEX_W{1'b0}};
        end else begin
            ID_EX <= id_ex_nxt_s;
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// ---------------------------------------------------------------------------
// tb_decode_stage
// Scoreboard bench for decode_stage. A fetch emulator presents words,
// honours stall and redirect, and a behavioural model predicts stall,
// redirect and the ID_EX word. Expected ID_EX words go into a queue that
// a separate monitor drains whenever the DUT shows a valid ID_EX.
// ---------------------------------------------------------------------------
module tb_decode_stage;

    logic         clock = 1'b0;
    logic         reset;
    logic [63:0]  IF_ID;
    logic         if_valid;
    logic [4:0]   ex_dest;
    logic         ex_regwrite;
    logic         wb_we;
    logic [4:0]   wb_addr;
    logic [31:0]  wb_data;
    logic         stall;
    logic         branchFlag;
    logic [31:0]  branchTarget;
    logic [149:0] ID_EX;

    always #5 clock = ~clock;

    decode_stage dut (
        .clock        (clock),
        .reset        (reset),
        .IF_ID        (IF_ID),
        .if_valid     (if_valid),
        .ex_dest      (ex_dest),
        .ex_regwrite  (ex_regwrite),
        .wb_we        (wb_we),
        .wb_addr      (wb_addr),
        .wb_data      (wb_data),
        .stall        (stall),
        .branchFlag   (branchFlag),
        .branchTarget (branchTarget),
        .ID_EX        (ID_EX)
    );

    int n_cmp = 0;
    int n_bad = 0;
    logic [149:0] exp_q [$];

    // Behavioural model state
    logic [31:0]  m_regs [32];
    logic [149:0] m_idex;    // what ID_EX holds this cycle
    logic [149:0] m_prev;    // what ID_EX held last cycle (now in EX/MEM)
    bit           m_first;   // first cycle after reset: stale word
    bit           m_squash;  // word after a taken branch: wrong path
    bit           m_stall;
    bit           m_taken;
    logic [31:0]  m_tgt;

    bit           rand_wb = 1'b0;
    logic         nx_we = 1'b0;
    logic [4:0]   nx_wa = 5'd0;
    logic [31:0]  nx_wd = 32'd0;

    task automatic chk(input string name, input logic [149:0] act, input logic [149:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mread(input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
        if (nx_we && (a == nx_wa)) return nx_wd;
        return m_regs[a];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
        m_idex   = 150'd0;
        m_prev   = 150'd0;
        m_first  = 1'b1;
        m_squash = 1'b0;
    endtask

    // Present one word for one clock; optionally assert reset mid-cycle
    task automatic cycle(input logic [31:0] pc, input logic [31:0] ins, input bit v, input bit rst_mid);
        logic [5:0]   op;
        logic [4:0]   rs, rt, rd, idd, dst;
        logic [31:0]  rsv, rtv, simm;
        logic [3:0]   ctl;
        logic [149:0] nxt;
        bit           act, urs, urt, lu, bh, hz;
        if (rand_wb) begin
            nx_we = ($urandom_range(0, 2) == 0);
            nx_wa = 5'($urandom_range(0, 7));
            nx_wd = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
        end
        IF_ID       = {pc, ins};
        if_valid    = v;
        wb_we       = nx_we;
        wb_addr     = nx_wa;
        wb_data     = nx_wd;
        ex_dest     = m_prev[132:128];
        ex_regwrite = m_prev[148];
        #3;
        op   = ins[31:26];
        rs   = ins[25:21];
        rt   = ins[20:16];
        rd   = ins[15:11];
        simm = {{16{ins[15]}}, ins[15:0]};
        rsv  = mread(rs);
        rtv  = mread(rt);
        act  = v && !m_first && !m_squash;
        urs  = (op == 6'h00) || (op == 6'h08) || (op == 6'h23) || (op == 6'h2B) || (op == 6'h04);
        urt  = (op == 6'h00) || (op == 6'h2B) || (op == 6'h04);
        idd  = m_idex[132:128];
        lu   = m_idex[149] && m_idex[147] && (idd != 5'd0) &&
               ((urs && rs == idd) || (urt && rt == idd));
        bh   = (op == 6'h04) &&
               ((rs != 5'd0 && ((m_idex[148] && rs == idd) || (ex_regwrite && rs == ex_dest))) ||
                (rt != 5'd0 && ((m_idex[148] && rt == idd) || (ex_regwrite && rt == ex_dest))));
        hz   = act && (lu || bh);
        m_stall = hz;
        m_taken = act && !hz && (((op == 6'h04) && (rsv == rtv)) || (op == 6'h02));
        if (!m_taken)          m_tgt = 32'd0;
        else if (op == 6'h04)  m_tgt = pc + 32'd1 + simm;
        else                   m_tgt = {6'd0, ins[25:0]};
        case (op)
            6'h00:   begin ctl = 4'b1000; dst = rd;   end
            6'h08:   begin ctl = 4'b1001; dst = rt;   end
            6'h23:   begin ctl = 4'b1101; dst = rt;   end
            6'h2B:   begin ctl = 4'b0011; dst = 5'd0; end
            default: begin ctl = 4'b0000; dst = 5'd0; end
        endcase
        nxt = (act && !hz) ? {1'b1, ctl, op, ins[5:0], dst, pc, rsv, rtv, simm} : 150'd0;
        chk("stall", 150'(stall), 150'(m_stall));
        chk("branchFlag", 150'(branchFlag), 150'(m_taken));
        chk("branchTarget", 150'(branchTarget), 150'(m_tgt));
        if (nxt[149]) exp_q.push_back(nxt);
        if (nx_we && nx_wa != 5'd0) m_regs[nx_wa] = nx_wd;
        m_prev   = m_idex;
        m_idex   = nxt;
        m_first  = 1'b0;
        m_squash = m_taken;
        nx_we    = 1'b0;
        if (rst_mid) begin
            reset = 1'b0;
            #1;
            chk("rst_id_ex", ID_EX, 150'd0);
            chk("rst_stall", 150'(stall), 150'd0);
            chk("rst_branchFlag", 150'(branchFlag), 150'd0);
            chk("rst_branchTarget", 150'(branchTarget), 150'd0);
            model_reset();
        end
        @(posedge clock);
        #2;
    endtask

    // Fetch emulation: hold the word while stalled, feed the wrong-path
    // word after a taken branch, and return the next fetch pc
    task automatic issue(input logic [31:0] pc, input logic [31:0] ins, output logic [31:0] npc);
        logic [31:0] t;
        int k;
        k = 0;
        do begin
            cycle(pc, ins, 1'b1, 1'b0);
            k++;
        end while (m_stall && k < 4);
        if (m_taken) begin
            t = m_tgt;
            cycle(pc + 32'd1, $urandom, 1'b1, 1'b0);
            npc = t;
        end else begin
            npc = pc + 32'd1;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(32'd0, 32'd0, 1'b0, 1'b0);
    endtask

    task automatic wb(input logic [4:0] a, input logic [31:0] d);
        nx_we = 1'b1;
        nx_wa = a;
        nx_wd = d;
        cycle(32'd0, 32'd0, 1'b0, 1'b0);
    endtask

    // Monitor: compare each valid ID_EX against the scoreboard; bubbles must be all zero
    initial begin
        forever begin
            @(posedge clock);
            #1;
            if (ID_EX[149]) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL id_ex_unexpected: got %h expected no valid word", ID_EX);
                end else begin
                    chk("id_ex", ID_EX, exp_q.pop_front());
                end
            end else begin
                chk("id_ex_bubble", ID_EX, 150'd0);
            end
        end
    end

    initial begin
        logic [31:0] npc, pc, ins;
        logic [5:0]  op;
        reset       = 1'b0;
        IF_ID       = 64'hEEEEEEEEEEEEEEEE;
        if_valid    = 1'b1;
        ex_dest     = 5'd0;
        ex_regwrite = 1'b0;
        wb_we       = 1'b0;
        wb_addr     = 5'd0;
        wb_data     = 32'd0;
        model_reset();
        #1;
        chk("reset_id_ex", ID_EX, 150'd0);
        chk("reset_stall", 150'(stall), 150'd0);
        chk("reset_branchFlag", 150'(branchFlag), 150'd0);
        chk("reset_branchTarget", 150'(branchTarget), 150'd0);
        #6;
        reset = 1'b1;
        // stale word right after reset must become a bubble
        cycle(32'hEEEEEEEE, 32'hEEEEEEEE, 1'b1, 1'b0);

        // ADDI r6,r5,-1 at pc=3 with r5=0x10
        wb(5'd5, 32'h10);
        issue(32'd3, {6'h08, 5'd5, 5'd6, 16'hFFFF}, npc);

        // load-use: LW r2,0(r1) then ADD r3,r2,r1
        wb(5'd1, 32'd7);
        wb(5'd2, 32'd7);
        issue(32'd4, {6'h23, 5'd1, 5'd2, 16'd0}, npc);
        issue(32'd5, {6'h00, 5'd2, 5'd1, 5'd3, 5'd0, 6'h20}, npc);
        idle(2);

        // taken BEQ r1,r2,+4 at pc=10, then continue from the target
        issue(32'd10, {6'h04, 5'd1, 5'd2, 16'd4}, npc);
        issue(npc, {6'h08, 5'd0, 5'd4, 16'd1}, npc);
        idle(2);

        // J 0x20 at pc=8
        issue(32'd8, {6'h02, 26'h20}, npc);
        issue(npc, {6'h00, 5'd1, 5'd2, 5'd7, 5'd0, 6'h20}, npc);

        // not-taken BEQ: no bubble, the next word issues directly
        wb(5'd2, 32'd9);
        idle(1);
        issue(32'd10, {6'h04, 5'd1, 5'd2, 16'd4}, npc);
        issue(npc, {6'h08, 5'd1, 5'd9, 16'd3}, npc);
        idle(2);

        // branch-operand hazard: ADDI r1 then BEQ on r1 (two bubbles)
        issue(32'd20, {6'h08, 5'd0, 5'd1, 16'd9}, npc);
        issue(32'd21, {6'h04, 5'd1, 5'd2, 16'hFFFE}, npc);
        issue(npc, {6'h08, 5'd0, 5'd5, 16'd2}, npc);
        idle(2);

        // reset asserted during a load-use stall
        issue(32'd30, {6'h23, 5'd1, 5'd2, 16'd0}, npc);
        cycle(32'd31, {6'h00, 5'd2, 5'd1, 5'd3, 5'd0, 6'h20}, 1'b1, 1'b1);
        reset = 1'b1;
        cycle(32'd31, {6'h00, 5'd2, 5'd1, 5'd3, 5'd0, 6'h20}, 1'b1, 1'b0);
        issue(32'd31, {6'h00, 5'd2, 5'd1, 5'd3, 5'd0, 6'h20}, npc);
        idle(2);

        // randomized traffic on a small register window
        rand_wb = 1'b1;
        pc = 32'd100;
        for (int n = 0; n < 400; n++) begin
            case ($urandom_range(0, 6))
                0:       op = 6'h00;
                1:       op = 6'h08;
                2:       op = 6'h23;
                3:       op = 6'h2B;
                4:       op = 6'h04;
                5:       op = 6'h02;
                default: op = 6'($urandom);
            endcase
            ins = {op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 16'($urandom)};
            ins[15:11] = 5'($urandom_range(0, 7));
            if ($urandom_range(0, 9) == 0) begin
                cycle(pc, ins, 1'b0, 1'b0);
            end else begin
                issue(pc, ins, npc);
                pc = npc;
            end
        end
        rand_wb = 1'b0;
        idle(3);

        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
